// File: rtl/gnss_pkg.sv
// Shared types and constants for the GNSS C/A code correlator.
package gnss_pkg;

  // C/A code length in chips (one 1 ms epoch).
  localparam int CA_CHIPS = 1023;

  // Code NCO increment for 1.023 MHz chipping at 4 MHz sampling.
  localparam logic [31:0] CODE_STEP_4M = 32'h4178_D4FE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } corr_state_t;

  // 2-bit sign/magnitude front-end sample -> signed value in {-3,-1,+1,+3}.
  function automatic logic signed [2:0] iq2_to_int(input logic d1, input logic d0);
    logic signed [2:0] mag;
    mag = d0 ? 3'sd3 : 3'sd1;
    return d1 ? -mag : mag;
  endfunction

endpackage

// File: rtl/code_nco.sv
// Code-rate NCO: phase accumulator whose carry advances the C/A generator.
module code_nco #(
  parameter int NCO_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [NCO_W-1:0] step_i,
  input  logic             adv_i,
  output logic             carry_o,
  output logic             code_rd_o
);

  logic [NCO_W-1:0] step_q;
  logic [NCO_W-1:0] phase_q;
  logic             code_rd_q;
  logic [NCO_W:0]   sum;

  // Phase wraps modulo 2^NCO_W; bit NCO_W of the sum is the chip carry.
  assign sum       = {1'b0, phase_q} + {1'b0, step_q};
  assign carry_o   = adv_i & sum[NCO_W];
  assign code_rd_o = code_rd_q;

  // Load step/clear phase on start, advance phase per sample, register carry as code_rd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q    <= '0;
      phase_q   <= '0;
      code_rd_q <= 1'b0;
    end else begin
      code_rd_q <= carry_o;
      if (load_i) begin
        step_q  <= step_i;
        phase_q <= '0;
      end else if (adv_i) begin
        phase_q <= sum[NCO_W-1:0];
      end
    end
  end

endmodule

// File: rtl/gnss_code_correlator.sv
// C/A code correlator: wipes the code chip off 2-bit I/Q samples and
// integrates them over 1023-chip epochs with sticky saturating accumulators.
// Handshake: s_valid is a one-cycle sample strobe (no backpressure); res_valid
// is a one-cycle strobe marking res_i/res_q as freshly updated.
module gnss_code_correlator
  import gnss_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int NCO_W = 32,
  parameter int CHIPS = CA_CHIPS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [NCO_W-1:0]        code_step,
  input  logic                    s_valid,
  input  logic                    i_d1,
  input  logic                    i_d0,
  input  logic                    q_d1,
  input  logic                    q_d0,
  input  logic                    chip,
  output logic                    code_rst,
  output logic                    code_rd,
  output logic signed [ACC_W-1:0] res_i,
  output logic signed [ACC_W-1:0] res_q,
  output logic                    res_valid,
  output logic                    busy,
  output corr_state_t             dbg_state
);

  localparam int CNT_W = $clog2(CHIPS);
  localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(CHIPS - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};

  // Returns {sat, acc}: once saturated the accumulator holds until cleared.
  function automatic logic [ACC_W:0] sat_acc(input logic [ACC_W-1:0] acc,
                                             input logic sat,
                                             input logic signed [2:0] w);
    logic signed [ACC_W:0] sum;
    logic [ACC_W:0] res;
    sum = $signed({acc[ACC_W-1], acc}) + $signed({{(ACC_W-2){w[2]}}, w});
    res = {sat, acc};
    if (!sat) begin
      if (sum > SAT_MAX)      res = {1'b1, SAT_MAX[ACC_W-1:0]};
      else if (sum < SAT_MIN) res = {1'b1, SAT_MIN[ACC_W-1:0]};
      else                    res = {1'b0, sum[ACC_W-1:0]};
    end
    return res;
  endfunction

  corr_state_t      state_q, state_d;
  logic             code_rst_q, code_rst_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic [ACC_W-1:0] res_i_q, res_i_d;
  logic [ACC_W-1:0] res_q_q, res_q_d;
  logic [ACC_W-1:0] acc_i_q, acc_i_d, acc_i_nx;
  logic [ACC_W-1:0] acc_q_q, acc_q_d, acc_q_nx;
  logic             sat_i_q, sat_i_d, sat_i_nx;
  logic             sat_q_q, sat_q_d, sat_q_nx;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             nco_load;
  logic             nco_adv;
  logic             carry;
  logic signed [2:0] val_i, val_q, wiped_i, wiped_q;

  assign nco_load = start && (state_q == IDLE);
  assign nco_adv  = s_valid && (state_q != IDLE);

  code_nco #(.NCO_W(NCO_W)) u_nco (
    .clk       (clk),
    .rst       (rst),
    .load_i    (nco_load),
    .step_i    (code_step),
    .adv_i     (nco_adv),
    .carry_o   (carry),
    .code_rd_o (code_rd)
  );

  // Code wipe-off of the current sample and the saturating accumulator updates.
  always_comb begin
    val_i   = iq2_to_int(i_d1, i_d0);
    val_q   = iq2_to_int(q_d1, q_d0);
    wiped_i = chip ? -val_i : val_i;
    wiped_q = chip ? -val_q : val_q;
    {sat_i_nx, acc_i_nx} = sat_acc(acc_i_q, sat_i_q, wiped_i);
    {sat_q_nx, acc_q_nx} = sat_acc(acc_q_q, sat_q_q, wiped_q);
  end

  // Next-state logic: start handshake, per-sample integration, epoch end, stop.
  always_comb begin
    state_d     = state_q;
    code_rst_d  = 1'b0;
    res_valid_d = 1'b0;
    res_i_d     = res_i_q;
    res_q_d     = res_q_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    sat_i_d     = sat_i_q;
    sat_q_d     = sat_q_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          code_rst_d = 1'b1;
          acc_i_d    = '0;
          acc_q_d    = '0;
          sat_i_d    = 1'b0;
          sat_q_d    = 1'b0;
          cnt_d      = '0;
        end
      end
      RUN, LAST: begin
        if (stop && (state_q == RUN)) state_d = LAST;
        if (s_valid) begin
          acc_i_d = acc_i_nx;
          acc_q_d = acc_q_nx;
          sat_i_d = sat_i_nx;
          sat_q_d = sat_q_nx;
          if (carry) begin
            if (cnt_q == LAST_CHIP) begin
              // This sample closes the epoch; phase keeps its remainder.
              res_i_d     = acc_i_nx;
              res_q_d     = acc_q_nx;
              res_valid_d = 1'b1;
              acc_i_d     = '0;
              acc_q_d     = '0;
              sat_i_d     = 1'b0;
              sat_q_d     = 1'b0;
              cnt_d       = '0;
              if (state_q == LAST) state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      code_rst_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      res_i_q     <= '0;
      res_q_q     <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      sat_i_q     <= 1'b0;
      sat_q_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      code_rst_q  <= code_rst_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      res_i_q     <= res_i_d;
      res_q_q     <= res_q_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      sat_i_q     <= sat_i_d;
      sat_q_q     <= sat_q_d;
      cnt_q       <= cnt_d;
    end
  end

  assign code_rst  = code_rst_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign res_i     = res_i_q;
  assign res_q     = res_q_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gnss_code_correlator.sv
// Bench for gnss_code_correlator: a 16-bit and a 12-bit accumulator instance
// share one stimulus stream; epoch results are checked from expected queues.
`timescale 1ns/1ps
module tb_gnss_code_correlator;
  import gnss_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, stop = 1'b0, s_valid = 1'b0, chip = 1'b0;
  logic        i_d1 = 1'b0, i_d0 = 1'b0, q_d1 = 1'b0, q_d0 = 1'b0;
  logic [31:0] code_step = '0;

  logic               code_rst16, code_rd16, res_valid16, busy16;
  logic signed [15:0] res_i16, res_q16;
  corr_state_t        dbg16;
  logic               code_rst12, code_rd12, res_valid12, busy12;
  logic signed [11:0] res_i12, res_q12;
  corr_state_t        dbg12;

  gnss_code_correlator #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .code_step(code_step),
    .s_valid(s_valid), .i_d1(i_d1), .i_d0(i_d0), .q_d1(q_d1), .q_d0(q_d0),
    .chip(chip), .code_rst(code_rst16), .code_rd(code_rd16), .res_i(res_i16),
    .res_q(res_q16), .res_valid(res_valid16), .busy(busy16), .dbg_state(dbg16)
  );

  gnss_code_correlator #(.ACC_W(12)) dut12 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .code_step(code_step),
    .s_valid(s_valid), .i_d1(i_d1), .i_d0(i_d0), .q_d1(q_d1), .q_d0(q_d0),
    .chip(chip), .code_rst(code_rst12), .code_rd(code_rd12), .res_i(res_i12),
    .res_q(res_q12), .res_valid(res_valid12), .busy(busy12), .dbg_state(dbg12)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q16[$];   // {res_i, res_q} for the 16-bit instance
  logic [23:0] exp_q12[$];   // {res_i, res_q} for the 12-bit instance
  int rd_cnt = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) if (code_rd16) rd_cnt++;

  // Monitor: pop and compare on every res_valid strobe.
  always @(negedge clk) begin
    logic [31:0] e16;
    logic [23:0] e12;
    if (res_valid16) begin
      if (exp_q16.size() == 0) chk("unexpected_res_valid16", 1, 0);
      else begin
        e16 = exp_q16.pop_front();
        chk("res_i16", res_i16, $signed(e16[31:16]));
        chk("res_q16", res_q16, $signed(e16[15:0]));
      end
    end
    if (res_valid12) begin
      if (exp_q12.size() == 0) chk("unexpected_res_valid12", 1, 0);
      else begin
        e12 = exp_q12.pop_front();
        chk("res_i12", res_i12, $signed(e12[23:12]));
        chk("res_q12", res_q12, $signed(e12[11:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One sample strobe, then two quiet cycles; rd is code_rd one cycle later.
  task automatic send(input logic i1, input logic i0, input logic q1,
                      input logic q0, output logic rd);
    @(negedge clk);
    s_valid = 1'b1; i_d1 = i1; i_d0 = i0; q_d1 = q1; q_d0 = q0;
    @(negedge clk);
    s_valid = 1'b0;
    rd = code_rd16;
    @(negedge clk);
  endtask

  // n samples of I = +3, Q = -1; optionally check code_rd on the first four.
  task automatic run_samples(input int n, input bit chk_rd);
    logic rd;
    for (int k = 0; k < n; k++) begin
      send(1'b0, 1'b1, 1'b1, 1'b0, rd);
      if (chk_rd && k < 4) chk($sformatf("code_rd_sample%0d", k + 1), rd, (k % 2 == 1));
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    code_step = 32'h8000_0000;
    @(negedge clk);
    start = 1'b0;
    chk("code_rst_after_start", code_rst16, 1);
    chk("busy_after_start", busy16, 1);
    chk("state_run", dbg16, RUN);
    @(negedge clk);
    chk("code_rst_one_cycle", code_rst16, 0);
  endtask

  task automatic push_exp(input int i16, input int q16, input int i12, input int q12);
    logic [15:0] a, b;
    logic [11:0] c, d;
    a = 16'(i16); b = 16'(q16); c = 12'(i12); d = 12'(q12);
    exp_q16.push_back({a, b});
    exp_q12.push_back({c, d});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rd0;
    logic rd;
    repeat (3) @(negedge clk);
    chk("rst_code_rst", code_rst16, 0);
    chk("rst_code_rd", code_rd16, 0);
    chk("rst_res_valid", res_valid16, 0);
    chk("rst_busy", busy16, 0);
    chk("rst_res_i", res_i16, 0);
    chk("rst_res_q", res_q16, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy16, 0);
    chk("idle_state", dbg16, IDLE);

    // Samples and stop in IDLE do nothing.
    code_step = 32'h8000_0000;
    rd0 = rd_cnt;
    stop = 1'b1;
    for (int k = 0; k < 3; k++) send(1'b0, 1'b1, 1'b1, 1'b0, rd);
    stop = 1'b0;
    chk("idle_no_code_rd", rd_cnt - rd0, 0);
    chk("idle_stop_ignored", dbg16, IDLE);

    // Epoch 1: chip 0.
    do_start();
    chip = 1'b0;
    push_exp(6138, -2046, 2047, -2046);
    rd0 = rd_cnt;
    run_samples(2046, 1'b1);
    chk("code_rd_per_epoch", rd_cnt - rd0, 1023);

    // Epochs 2 and 3: chip 1, back to back.
    chip = 1'b1;
    push_exp(-6138, 2046, -2047, 2046);
    push_exp(-6138, 2046, -2047, 2046);
    run_samples(4092, 1'b0);
    chk("busy_between_epochs", busy16, 1);

    // Epoch 4: chip 0, stop mid-epoch; saturating instance recovers to +2047.
    chip = 1'b0;
    push_exp(6138, -2046, 2047, -2046);
    run_samples(100, 1'b0);
    @(negedge clk);
    stop = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b0;
    chk("state_last", dbg16, LAST);
    chk("busy_in_last", busy16, 1);
    run_samples(1946, 1'b0);
    chk("busy_after_stop", busy16, 0);
    chk("state_idle_after_stop", dbg16, IDLE);
    chk("busy12_after_stop", busy12, 0);
    rd0 = rd_cnt;
    run_samples(4, 1'b0);
    chk("no_code_rd_after_stop", rd_cnt - rd0, 0);

    // Reset mid-epoch: outputs clear at once, no result.
    do_start();
    run_samples(500, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_res_i", res_i16, 0);
    chk("async_rst_res_q", res_q16, 0);
    chk("async_rst_res_i12", res_i12, 0);
    chk("async_rst_busy", busy16, 0);
    chk("async_rst_state", dbg16, IDLE);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run_samples(4, 1'b0);
    chk("post_rst_busy", busy16, 0);

    repeat (5) @(negedge clk);
    chk("exp_q16_drained", exp_q16.size(), 0);
    chk("exp_q12_drained", exp_q12.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
